// File: rtl/ph_bytequad_sync.sv
// ph_bytequad_sync: parasite-to-host Tube registers R1..R4, single clock.
// R1 is a circular FIFO of R1_DEPTH bytes, R2/R4 hold one byte, R3 holds
// one or two bytes depending on one_byte_mode (a mode change flushes R3).
// Ports: h_phi2 clock, h_rst_b async active-low reset; parasite side
// p_we/p_selectData/p_data, p_full; host side h_rd/h_selectData, h_data,
// h_data_available, h_r3_two_bytes_available, h_r1_count.
// Optional macro PH_R1_OVERFLOW_EN adds sticky output p_r1_overflow.
module ph_bytequad_sync #(
    parameter int R1_DEPTH = 24,
    parameter int CW       = 5
) (
    input  logic          h_phi2,
    input  logic          h_rst_b,
    input  logic          p_we,
    input  logic [3:0]    p_selectData,
    input  logic [7:0]    p_data,
    input  logic          h_rd,
    input  logic [3:0]    h_selectData,
    input  logic          one_byte_mode,
    output logic [7:0]    h_data,
    output logic [3:0]    h_data_available,
    output logic          h_r3_two_bytes_available,
    output logic [3:0]    p_full,
    output logic [CW-1:0] h_r1_count
`ifdef PH_R1_OVERFLOW_EN
    ,
    output logic          p_r1_overflow
`endif
);

    localparam int PW = (R1_DEPTH > 2) ? $clog2(R1_DEPTH) : 1;
    localparam logic [PW-1:0] LAST  = PW'(R1_DEPTH - 1);
    localparam logic [CW-1:0] FULLC = CW'(R1_DEPTH);

    logic [7:0]    r1_mem [R1_DEPTH];
    logic [PW-1:0] r1_wp, r1_rp;
    logic [CW-1:0] r1_cnt;
    logic [7:0]    r2_q, r4_q;
    logic          r2_v, r4_v;
    logic [7:0]    r3_b0, r3_b1;
    logic [1:0]    r3_cnt;
    logic          mode_q;

    logic [3:0] psel, hsel, wr, rd, nonempty, full, pop, push;
    logic       flush;

    // Isolate the lowest set bit so non-one-hot selects pick one register.
    assign psel = p_selectData & (~p_selectData + 4'd1);
    assign hsel = h_selectData & (~h_selectData + 4'd1);

    assign wr = {4{p_we}} & psel;
    assign rd = {4{h_rd}} & hsel;

    assign nonempty = {r4_v, r3_cnt != 2'd0, r2_v, r1_cnt != '0};
    // R3 capacity follows the mode its current contents were written in.
    assign full = {r4_v,
                   mode_q ? (r3_cnt == 2'd1) : (r3_cnt == 2'd2),
                   r2_v,
                   r1_cnt == FULLC};

    assign pop   = rd & nonempty;
    // A full register still accepts a push when the same edge pops it.
    assign push  = wr & (~full | pop);
    assign flush = one_byte_mode != mode_q;

    assign p_full = full;
    assign h_data_available = {r4_v,
                               mode_q ? (r3_cnt != 2'd0) : (r3_cnt == 2'd2),
                               r2_v,
                               r1_cnt != '0};
    assign h_r3_two_bytes_available = ~mode_q & (r3_cnt == 2'd2);
    assign h_r1_count = r1_cnt;

    always_comb begin
        h_data = 8'h00;
        unique case (1'b1)
            hsel[0]: h_data = nonempty[0] ? r1_mem[r1_rp] : 8'h00;
            hsel[1]: h_data = r2_v ? r2_q : 8'h00;
            hsel[2]: h_data = nonempty[2] ? r3_b0 : 8'h00;
            hsel[3]: h_data = r4_v ? r4_q : 8'h00;
            default: h_data = 8'h00;
        endcase
    end

    always_ff @(posedge h_phi2) begin
        if (push[0]) r1_mem[r1_wp] <= p_data;
    end

    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            r1_wp  <= '0;
            r1_rp  <= '0;
            r1_cnt <= '0;
        end else begin
            if (push[0]) r1_wp <= (r1_wp == LAST) ? '0 : r1_wp + 1'b1;
            if (pop[0])  r1_rp <= (r1_rp == LAST) ? '0 : r1_rp + 1'b1;
            if (push[0] && !pop[0])      r1_cnt <= r1_cnt + CW'(1);
            else if (pop[0] && !push[0]) r1_cnt <= r1_cnt - CW'(1);
        end
    end

    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            r2_q <= 8'h00;
            r2_v <= 1'b0;
            r4_q <= 8'h00;
            r4_v <= 1'b0;
        end else begin
            if (push[1])     begin r2_q <= p_data; r2_v <= 1'b1; end
            else if (pop[1]) r2_v <= 1'b0;
            if (push[3])     begin r4_q <= p_data; r4_v <= 1'b1; end
            else if (pop[3]) r4_v <= 1'b0;
        end
    end

    // R3 is a two-entry shift FIFO; b0 is always the head.
    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            r3_b0  <= 8'h00;
            r3_b1  <= 8'h00;
            r3_cnt <= 2'd0;
            mode_q <= 1'b0;
        end else begin
            mode_q <= one_byte_mode;
            if (flush) begin
                r3_cnt <= 2'd0;
            end else if (push[2] && pop[2]) begin
                if (r3_cnt == 2'd1) begin
                    r3_b0 <= p_data;
                end else begin
                    r3_b0 <= r3_b1;
                    r3_b1 <= p_data;
                end
            end else if (pop[2]) begin
                r3_b0  <= r3_b1;
                r3_cnt <= r3_cnt - 2'd1;
            end else if (push[2]) begin
                if (r3_cnt == 2'd0) r3_b0 <= p_data;
                else                r3_b1 <= p_data;
                r3_cnt <= r3_cnt + 2'd1;
            end
        end
    end

`ifdef PH_R1_OVERFLOW_EN
    logic ovf_set;
    assign ovf_set = wr[0] & full[0] & ~pop[0];

    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b)     p_r1_overflow <= 1'b0;
        else if (ovf_set) p_r1_overflow <= 1'b1;
        else if (pop[0])  p_r1_overflow <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_ph_bytequad_sync.sv
// tb_ph_bytequad_sync: directed scenarios plus randomized traffic for
// ph_bytequad_sync, checked against a queue-style reference model.
module tb_ph_bytequad_sync;

    localparam int R1_DEPTH = 24;
    localparam int CW       = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p_we = 1'b0;
    logic [3:0]    p_sel = 4'h0;
    logic [7:0]    p_dat = 8'h00;
    logic          h_rd = 1'b0;
    logic [3:0]    h_sel = 4'h0;
    logic          obm = 1'b0;
    logic [7:0]    h_data;
    logic [3:0]    avail;
    logic          two;
    logic [3:0]    p_full;
    logic [CW-1:0] r1_count;
`ifdef PH_R1_OVERFLOW_EN
    logic          ovf;
`endif

    int errs = 0;
    int checks = 0;

    // Reference model: each register is a head-first byte array plus a count.
    logic [7:0] m [4][0:31];
    int         cnt [4];
    logic       mprev;
    logic       ov;

    always #5 clk = ~clk;

    ph_bytequad_sync #(.R1_DEPTH(R1_DEPTH), .CW(CW)) dut (
        .h_phi2                   (clk),
        .h_rst_b                  (rst_n),
        .p_we                     (p_we),
        .p_selectData             (p_sel),
        .p_data                   (p_dat),
        .h_rd                     (h_rd),
        .h_selectData             (h_sel),
        .one_byte_mode            (obm),
        .h_data                   (h_data),
        .h_data_available         (avail),
        .h_r3_two_bytes_available (two),
        .p_full                   (p_full),
        .h_r1_count               (r1_count)
`ifdef PH_R1_OVERFLOW_EN
        ,
        .p_r1_overflow            (ovf)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowbit(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return i;
        return -1;
    endfunction

    function automatic int depth(input int i);
        case (i)
            0:       return R1_DEPTH;
            2:       return mprev ? 1 : 2;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        mprev = 1'b0;
        ov = 1'b0;
    endtask

    task automatic check_flags();
        logic [3:0] ea, ef;
        for (int i = 0; i < 4; i++) begin
            ef[i] = (cnt[i] == depth(i));
            ea[i] = (i == 2 && !mprev) ? (cnt[i] == 2) : (cnt[i] > 0);
        end
        check("avail", int'(avail), int'(ea));
        check("p_full", int'(p_full), int'(ef));
        check("two_bytes", int'(two), int'(!mprev && cnt[2] == 2));
        check("r1_count", int'(r1_count), cnt[0]);
`ifdef PH_R1_OVERFLOW_EN
        check("overflow", int'(ovf), int'(ov));
`endif
    endtask

    // One clock: drive inputs, check h_data before the edge, then advance
    // the model and check the registered flags after the edge.
    task automatic step(input logic we, input logic [3:0] ps,
                        input logic [7:0] d, input logic rd,
                        input logic [3:0] hs, input logic mode);
        int pi, hi, ehd;
        logic fl, full0, popped0;
        p_we = we; p_sel = ps; p_dat = d;
        h_rd = rd; h_sel = hs; obm = mode;
        #3;
        hi = lowbit(hs);
        ehd = (hi >= 0 && cnt[hi] > 0) ? int'(m[hi][0]) : 0;
        check("h_data", int'(h_data), ehd);
        @(posedge clk);
        #1;
        pi = we ? lowbit(ps) : -1;
        hi = rd ? lowbit(hs) : -1;
        fl = (mode != mprev);
        full0 = (cnt[0] == R1_DEPTH);
        popped0 = 1'b0;
        if (fl) cnt[2] = 0;
        if (hi >= 0 && !(hi == 2 && fl) && cnt[hi] > 0) begin
            for (int j = 0; j < 31; j++) m[hi][j] = m[hi][j+1];
            cnt[hi]--;
            if (hi == 0) popped0 = 1'b1;
        end
        if (pi >= 0 && !(pi == 2 && fl) && cnt[pi] < depth(pi)) begin
            m[pi][cnt[pi]] = d;
            cnt[pi]++;
        end
        if (pi == 0 && full0 && !popped0) ov = 1'b1;
        else if (popped0) ov = 1'b0;
        mprev = mode;
        check_flags();
    endtask

    initial begin
        int rp;
        logic [3:0] s;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_flags();
        h_sel = 4'b0001;
        #1;
        check("reset_h_data", int'(h_data), 0);

        // Reset asserted between edges while R1 holds data.
        for (int i = 0; i < 3; i++) step(1, 4'b0001, 8'(8'h30 + i), 0, 0, 0);
        p_we = 0; h_rd = 0; h_sel = 4'b0001;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_count", int'(r1_count), 0);
        check("rst_avail", int'(avail), 0);
        check("rst_full", int'(p_full), 0);
        check("rst_h_data", int'(h_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_flags();

        // R1 fill, overflow, drain and wrap.
        for (int i = 0; i < 24; i++) step(1, 4'b0001, 8'(i), 0, 0, 0);
        check("r1_full", int'(p_full[0]), 1);
        check("r1_cnt24", int'(r1_count), 24);
        step(1, 4'b0001, 8'hAA, 0, 0, 0);
        check("r1_cnt_drop", int'(r1_count), 24);
`ifdef PH_R1_OVERFLOW_EN
        check("r1_ovf_set", int'(ovf), 1);
`endif
        for (int i = 0; i < 24; i++) begin
            h_sel = 4'b0001;
            #1;
            check("r1_order", int'(h_data), i);
            step(0, 0, 0, 1, 4'b0001, 0);
        end
        step(1, 4'b0001, 8'h55, 0, 0, 0);
        h_sel = 4'b0001;
        #1;
        check("r1_wrap_data", int'(h_data), 8'h55);
        step(0, 0, 0, 1, 4'b0001, 0);
        check("r1_wrap_empty", int'(avail[0]), 0);

        // Full R2, push and pop on the same edge.
        step(1, 4'b0010, 8'h11, 0, 0, 0);
        h_sel = 4'b0010;
        #1;
        check("r2_before", int'(h_data), 8'h11);
        step(1, 4'b0010, 8'h22, 1, 4'b0010, 0);
        check("r2_full", int'(p_full[1]), 1);
        #1;
        check("r2_after", int'(h_data), 8'h22);

        // R3 two-byte mode.
        step(1, 4'b0100, 8'hA1, 0, 0, 0);
        check("r3_one_avail", int'(avail[2]), 0);
        check("r3_one_full", int'(p_full[2]), 0);
        step(1, 4'b0100, 8'hA2, 0, 0, 0);
        check("r3_two_avail", int'(avail[2]), 1);
        check("r3_two_flag", int'(two), 1);
        check("r3_two_full", int'(p_full[2]), 1);
        h_sel = 4'b0100;
        #1;
        check("r3_pop1", int'(h_data), 8'hA1);
        step(0, 0, 0, 1, 4'b0100, 0);
        #1;
        check("r3_pop2", int'(h_data), 8'hA2);
        step(0, 0, 0, 1, 4'b0100, 0);

        // R3 mode flip flushes and drops the simultaneous push.
        step(1, 4'b0100, 8'hB1, 0, 0, 0);
        step(1, 4'b0100, 8'hB2, 0, 0, 1);
        check("flip_flushed", int'(avail[2]), 0);
        step(1, 4'b0100, 8'hC3, 0, 0, 1);
        check("flip_full", int'(p_full[2]), 1);
        check("flip_avail", int'(avail[2]), 1);

        // Non-one-hot selects.
        step(0, 0, 0, 1, 4'b0010, 1);
        step(1, 4'b1010, 8'h77, 0, 0, 1);
        check("nonhot_r4", int'(avail[3]), 0);
        check("nonhot_r2", int'(avail[1]), 1);
        h_sel = 4'b1010;
        #1;
        check("nonhot_read", int'(h_data), 8'h77);
        step(0, 0, 0, 1, 4'b1010, 1);

        // Randomized traffic, alternating fill-biased and drain-biased phases.
        for (int k = 0; k < 4000; k++) begin
            logic we, rd, md;
            logic [3:0] ps, hs;
            rp = ((k / 400) % 2 == 0) ? 25 : 70;
            we = ($urandom_range(0, 99) < 60);
            rd = ($urandom_range(0, 99) < rp);
            if ($urandom_range(0, 1) == 0) begin
                s = 4'b0001;
                ps = s << $urandom_range(0, 3);
            end else begin
                ps = 4'($urandom);
            end
            if ($urandom_range(0, 1) == 0) begin
                s = 4'b0001;
                hs = s << $urandom_range(0, 3);
            end else begin
                hs = 4'($urandom);
            end
            md = ($urandom_range(0, 49) == 0) ? ~obm : obm;
            step(we, ps, 8'($urandom), rd, hs, md);
        end

        step(0, 0, 0, 0, 0, obm);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
